// File: rtl/riscv_lsu.sv
// Load/store unit: bridges the core data port to a word-wide memory with a ready handshake,
// handling byte lanes, load extension, misalignment and bus timeouts.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [31:0]   addr_q;
  logic [31:0]   wd_q;
  logic [2:0]    size_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;

  logic          faulty;
  logic          timeout_hit;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  always_comb begin
    case (core_size_i)
      3'd0, 3'd4: faulty = 1'b0;
      3'd1, 3'd5: faulty = core_addr_i[0];
      3'd2:       faulty = |core_addr_i[1:0];
      default:    faulty = 1'b1;
    endcase
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Pick the addressed lane out of the read word, then extend by funct3[2] (unsigned variants).
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_rd_i[7:0];
      2'd1:    ld_byte = mem_rd_i[15:8];
      2'd2:    ld_byte = mem_rd_i[23:16];
      default: ld_byte = mem_rd_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rd_i;
    endcase
  end

  always_comb begin
    core_rd_o    = '0;
    core_stall_o = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_be_o     = '0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE: begin
          if (core_req_i) begin
            misalign_o   = faulty;
            core_stall_o = !faulty;
          end
        end
        BUSY: begin
          mem_req_o  = 1'b1;
          mem_we_o   = we_q;
          mem_addr_o = {addr_q[31:2], 2'b00};
          case (size_q[1:0])
            2'd0:    mem_wd_o = {4{wd_q[7:0]}};
            2'd1:    mem_wd_o = {2{wd_q[15:0]}};
            default: mem_wd_o = wd_q;
          endcase
          if (!we_q) begin
            mem_be_o = 4'b1111;
          end else begin
            case (size_q[1:0])
              2'd0:    mem_be_o = 4'b0001 << addr_q[1:0];
              2'd1:    mem_be_o = addr_q[1] ? 4'b1100 : 4'b0011;
              default: mem_be_o = 4'b1111;
            endcase
          end
          // Ready takes priority over a timeout landing in the same cycle.
          if (mem_ready_i) begin
            core_rd_o = ld_ext;
          end else if (timeout_hit) begin
            bus_err_o = 1'b1;
          end else begin
            core_stall_o = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      addr_q <= '0;
      wd_q   <= '0;
      size_q <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_req_i && !faulty) begin
            addr_q <= core_addr_i;
            wd_q   <= core_wd_i;
            size_q <= core_size_i;
            we_q   <= core_we_i;
            cnt_q  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready_i || timeout_hit) begin
            state <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: expected transaction results are queued when a request is
// driven and compared when the unit completes, faults, or times out.
module tb_riscv_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;
  logic        misalign_o;
  logic        bus_err_o;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        mis;
    int          busy;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drive one access; readyAt is the BUSY cycle index where ready is raised, -1 for never.
  task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rdata, input int readyAt);
    exp_t e;
    logic [31:0] sh;
    bit done;
    e.we   = we;
    e.addr = {addr[31:2], 2'b00};
    e.mis  = (size == 3'd3) || (size > 3'd5) ||
             ((size == 3'd1 || size == 3'd5) && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    if (!we)              e.be = 4'hF;
    else if (size == 3'd0) e.be = 4'(1 << addr[1:0]);
    else if (size == 3'd1) e.be = addr[1] ? 4'hC : 4'h3;
    else                   e.be = 4'hF;
    e.wd = (size == 3'd0) ? {4{wd[7:0]}} : (size == 3'd1) ? {2{wd[15:0]}} : wd;
    sh = (size == 3'd0 || size == 3'd4) ? rdata >> (8 * addr[1:0]) : rdata >> (16 * addr[1]);
    case (size)
      3'd0:    e.rd = 32'($signed(sh[7:0]));
      3'd4:    e.rd = {24'd0, sh[7:0]};
      3'd1:    e.rd = 32'($signed(sh[15:0]));
      3'd5:    e.rd = {16'd0, sh[15:0]};
      default: e.rd = rdata;
    endcase
    e.err  = (readyAt < 0 || readyAt > 3);
    e.busy = e.err ? 4 : readyAt + 1;
    if (e.err || e.mis || we) e.rd = 32'd0;
    sb.push_back(e);

    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = we; core_size_i = size; core_addr_i = addr;
    core_wd_i = wd; mem_rd_i = rdata; mem_ready_i = 1'b0;
    #1;
    if (e.mis) begin
      e = sb.pop_front();
      checkOutput("misalign", 32'(misalign_o), 32'(e.mis));
      checkOutput("mis_stall", 32'(core_stall_o), 32'd0);
      checkOutput("mis_memreq", 32'(mem_req_o), 32'd0);
      checkOutput("mis_rd", core_rd_o, 32'd0);
    end else begin
      checkOutput("capture_stall", 32'(core_stall_o), 32'd1);
      checkOutput("capture_memreq", 32'(mem_req_o), 32'd0);
      done = 1'b0;
      for (int k = 0; k < 12 && !done; k++) begin
        @(negedge clk_i);
        mem_ready_i = (k == readyAt);
        #1;
        checkOutput("busy_memreq", 32'(mem_req_o), 32'd1);
        checkOutput("busy_addr", mem_addr_o, sb[0].addr);
        checkOutput("busy_be", 32'(mem_be_o), 32'(sb[0].be));
        checkOutput("busy_we", 32'(mem_we_o), 32'(sb[0].we));
        if (sb[0].we) checkOutput("busy_wd", mem_wd_o, sb[0].wd);
        if (!core_stall_o) begin
          done = 1'b1;
          e = sb.pop_front();
          checkOutput("busy_cycles", 32'(k + 1), 32'(e.busy));
          checkOutput("load_rd", core_rd_o, e.rd);
          checkOutput("bus_err", 32'(bus_err_o), 32'(e.err));
        end
      end
      if (!done) begin
        checkOutput("completion_bound", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
    @(negedge clk_i);
    core_req_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    checkOutput("idle_stall", 32'(core_stall_o), 32'd0);
    checkOutput("idle_memreq", 32'(mem_req_o), 32'd0);
    checkOutput("idle_pulses", {30'd0, misalign_o, bus_err_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h100; core_wd_i = '0; mem_rd_i = 32'hFFFF_FFFF; mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    checkOutput("reset_stall", 32'(core_stall_o), 32'd0);
    checkOutput("reset_memreq", 32'(mem_req_o), 32'd0);
    checkOutput("reset_rd", core_rd_o, 32'd0);
    rst_i = 1'b0; core_req_i = 1'b0;
    @(negedge clk_i); #1;
    checkOutput("idle_ready_ignored", {core_rd_o[30:0], core_stall_o}, 32'd0);
    mem_ready_i = 1'b0;

    applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    applyStimulus(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0011, 1);
    applyStimulus(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0011, 0);
    applyStimulus(1'b0, 3'd1, 32'h102, 32'h0, 32'h8001_7FFE, 0);
    applyStimulus(1'b0, 3'd5, 32'h100, 32'h0, 32'h8001_FFFE, 2);
    applyStimulus(1'b0, 3'd4, 32'h101, 32'h0, 32'h1122_3344, 0);
    applyStimulus(1'b1, 3'd1, 32'h102, 32'h1234_ABCD, 32'h0, 2);
    applyStimulus(1'b1, 3'd0, 32'h101, 32'h0000_0055, 32'h0, 0);
    applyStimulus(1'b1, 3'd2, 32'h104, 32'hCAFE_F00D, 32'h0, 0);
    applyStimulus(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 3'd1, 32'h103, 32'h0, 32'h0, 0);
    applyStimulus(1'b1, 3'd2, 32'h102, 32'h0, 32'h0, 0);
    applyStimulus(1'b0, 3'd2, 32'h200, 32'h0, 32'h1234_5678, -1);
    applyStimulus(1'b0, 3'd2, 32'h204, 32'h0, 32'h8765_4321, 3);

    // Abandon a load mid-flight with reset, then confirm a fresh load still works.
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2; core_addr_i = 32'h300;
    @(negedge clk_i);
    #1;
    checkOutput("pre_reset_busy", 32'(mem_req_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("rst_busy_memreq", 32'(mem_req_o), 32'd0);
    checkOutput("rst_busy_stall", 32'(core_stall_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; core_req_i = 1'b0;
    #1;
    checkOutput("post_rst_memreq", 32'(mem_req_o), 32'd0);
    checkOutput("post_rst_err", 32'(bus_err_o), 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h300, 32'h0, 32'hA5A5_5A5A, 0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
